// File: rtl/ov_video_to_axis.sv
// rtl/ov_video_to_axis.sv - pixel-clock video to AXI4-Stream video bridge with framing checks
// Video is captured, framed into {sof, eol, pixel} words and buffered for downstream backpressure.

module ov_video_to_axis_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_V = (AW + 2)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      mem_count;
  logic [AW+1:0]    occupancy;
  logic             mem_empty;
  logic             push;
  logic             pop;
  logic             load;

  // Occupancy includes the registered head word so the usable depth is exactly DEPTH.
  assign mem_count = wr_ptr - rd_ptr;
  assign mem_empty = (wr_ptr == rd_ptr);
  assign occupancy = {1'b0, mem_count} + {{(AW + 1){1'b0}}, rd_valid};
  assign full      = (occupancy == DEPTH_V);
  assign push      = wr_en && !full;
  assign pop       = rd_valid && rd_ready;
  assign load      = !mem_empty && (!rd_valid || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (load) begin
        rd_ptr   <= rd_ptr + (AW + 1)'(1);
        rd_valid <= 1'b1;
        rd_data  <= mem[rd_ptr[AW-1:0]];
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

module ov_video_to_axis #(
  parameter int DATA_WIDTH   = 24,
  parameter int IMAGE_WIDTH  = 1280,
  parameter int IMAGE_HEIGHT = 720,
  parameter int FIFO_DEPTH   = 2048
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  vid_ce,
  input  logic                  vid_vs,
  input  logic                  vid_hs,
  input  logic                  vid_de,
  input  logic [DATA_WIDTH-1:0] vid_rgb,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  ovf_pulse,
  output logic                  fmt_err_pulse,
  output logic [15:0]           frame_cnt
);
  localparam int XW = $clog2(IMAGE_WIDTH) + 1;
  localparam int YW = $clog2(IMAGE_HEIGHT) + 1;
  localparam int FW = DATA_WIDTH + 2;
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);

  if (FIFO_DEPTH < 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 16");
  end

  typedef enum logic [0:0] {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [XW-1:0]   x, x_n;
  logic [YW-1:0]   y, y_n;
  logic            vs_d, vs_d_n;
  logic            de_d, de_d_n;
  logic [15:0]     frame_cnt_n;
  logic            ovf_n;
  logic            fmt_n;

  logic                  cap_ce;
  logic                  cap_vs;
  logic                  cap_de;
  logic [DATA_WIDTH-1:0] cap_rgb;

  logic          fifo_push;
  logic          fifo_full;
  logic [FW-1:0] fifo_wr_data;
  logic [FW-1:0] fifo_head;
  logic          sof;
  logic          eol;
  logic          unused_hs;

  assign unused_hs = vid_hs;

  // Input capture stage: the framing logic only ever sees registered video.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cap_ce  <= 1'b0;
      cap_vs  <= 1'b0;
      cap_de  <= 1'b0;
      cap_rgb <= '0;
    end else begin
      cap_ce <= vid_ce;
      if (vid_ce) begin
        cap_vs  <= vid_vs;
        cap_de  <= vid_de;
        cap_rgb <= vid_rgb;
      end
    end
  end

  assign sof          = (x == '0) && (y == '0);
  assign eol          = (x == X_LAST);
  assign fifo_wr_data = {sof, eol, cap_rgb};

  always_comb begin
    state_n     = state;
    x_n         = x;
    y_n         = y;
    vs_d_n      = vs_d;
    de_d_n      = de_d;
    frame_cnt_n = frame_cnt;
    ovf_n       = 1'b0;
    fmt_n       = 1'b0;
    fifo_push   = 1'b0;
    if (cap_ce) begin
      vs_d_n = cap_vs;
      de_d_n = cap_de;
      case (state)
        ST_SYNC: begin
          if (vs_d && !cap_vs) begin
            state_n = ST_ACTIVE;
            x_n     = '0;
            y_n     = '0;
          end
        end
        ST_ACTIVE: begin
          // A vs rise here is an early frame end and also the next frame's sync.
          if (!vs_d && cap_vs) begin
            fmt_n   = 1'b1;
            state_n = ST_SYNC;
          end else if (cap_de) begin
            if (fifo_full) begin
              ovf_n   = 1'b1;
              state_n = ST_SYNC;
            end else begin
              fifo_push = 1'b1;
              if (eol) begin
                x_n = '0;
                y_n = y + YW'(1);
                if (y == Y_LAST) begin
                  frame_cnt_n = frame_cnt + 16'd1;
                  state_n     = ST_SYNC;
                end
              end else begin
                x_n = x + XW'(1);
              end
            end
          end else if (de_d && (x != '0)) begin
            fmt_n   = 1'b1;
            state_n = ST_SYNC;
          end
        end
        default: state_n = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state         <= ST_SYNC;
      x             <= '0;
      y             <= '0;
      vs_d          <= 1'b0;
      de_d          <= 1'b0;
      frame_cnt     <= '0;
      ovf_pulse     <= 1'b0;
      fmt_err_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      x             <= x_n;
      y             <= y_n;
      vs_d          <= vs_d_n;
      de_d          <= de_d_n;
      frame_cnt     <= frame_cnt_n;
      ovf_pulse     <= ovf_n;
      fmt_err_pulse <= fmt_n;
    end
  end

  ov_video_to_axis_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (pclk),
    .rst      (rst),
    .wr_en    (fifo_push),
    .wr_data  (fifo_wr_data),
    .full     (fifo_full),
    .rd_valid (m_axis_tvalid),
    .rd_ready (m_axis_tready),
    .rd_data  (fifo_head)
  );

  assign m_axis_tuser = fifo_head[FW-1];
  assign m_axis_tlast = fifo_head[FW-2];
  assign m_axis_tdata = fifo_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_ov_video_to_axis.sv
// tb/tb_ov_video_to_axis.sv - directed bench for ov_video_to_axis (W=8, H=4, 16-entry FIFO)
// Expected beats are built from the frame geometry each scenario drives.

module tb_ov_video_to_axis;
  localparam int W = 8;
  localparam int H = 4;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vid_ce = 1'b0;
  logic        vid_vs = 1'b0;
  logic        vid_hs = 1'b0;
  logic        vid_de = 1'b0;
  logic [23:0] vid_rgb = '0;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        ovf_pulse;
  logic        fmt_err_pulse;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int ovf_seen = 0;
  int fmt_seen = 0;
  logic [25:0] act_q[$];
  logic [25:0] exp_q[$];

  ov_video_to_axis #(
    .DATA_WIDTH   (24),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .FIFO_DEPTH   (16)
  ) dut (
    .pclk          (pclk),
    .rst           (rst),
    .vid_ce        (vid_ce),
    .vid_vs        (vid_vs),
    .vid_hs        (vid_hs),
    .vid_de        (vid_de),
    .vid_rgb       (vid_rgb),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .ovf_pulse     (ovf_pulse),
    .fmt_err_pulse (fmt_err_pulse),
    .frame_cnt     (frame_cnt)
  );

  always #5 pclk = ~pclk;

  // Inputs change at posedge+2, so a negedge sample shows what the next posedge consumes.
  always @(negedge pclk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) act_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      if (ovf_pulse) ovf_seen++;
      if (fmt_err_pulse) fmt_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [23:0] pix(input int f, input int yy, input int xx);
    return {8'(f), 8'(yy), 8'(xx)};
  endfunction

  task automatic drive(input logic ce, input logic vs, input logic de, input logic [23:0] rgb);
    @(posedge pclk);
    #2;
    vid_ce  = ce;
    vid_vs  = vs;
    vid_de  = de;
    vid_rgb = rgb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic send_frame(input int fid, input int nlines, input int short_idx,
                            input int short_len, input bit ce_tog);
    drive(1'b1, 1'b1, 1'b0, 24'h0);
    drive(1'b1, 1'b1, 1'b0, 24'h0);
    idle(2);
    for (int l = 0; l < nlines; l++) begin
      for (int xx = 0; xx < ((l == short_idx) ? short_len : W); xx++) begin
        drive(1'b1, 1'b0, 1'b1, pix(fid, l, xx));
        if (ce_tog) drive(1'b0, 1'b0, 1'b1, 24'hBADBAD);
      end
      idle(2);
    end
  endtask

  task automatic exp_frame(input int fid, input int full_lines, input int part_len);
    for (int l = 0; l < full_lines; l++)
      for (int xx = 0; xx < W; xx++)
        exp_q.push_back({(xx == 0 && l == 0), (xx == W - 1), pix(fid, l, xx)});
    for (int xx = 0; xx < part_len; xx++)
      exp_q.push_back({(xx == 0 && full_lines == 0), 1'b0, pix(fid, full_lines, xx)});
  endtask

  task automatic drain_and_compare(input string tag);
    idle(40);
    check({tag, "_drained"}, m_axis_tvalid, 1'b0);
    check({tag, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) check(tag, act_q[i], exp_q[i]);
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge pclk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_pulses", {ovf_pulse, fmt_err_pulse}, 0);
    @(posedge pclk);
    #2 rst = 1'b0;
    idle(2);

    // Two good frames with first-beat latency measured from the first sampled de.
    m_axis_tready = 1'b1;
    fork
      begin
        @(posedge vid_de);
        @(posedge pclk); #1 check("lat_k", m_axis_tvalid, 0);
        @(posedge pclk); #1 check("lat_k1", m_axis_tvalid, 0);
        @(posedge pclk); #1 check("lat_k2", m_axis_tvalid, 1);
      end
      send_frame(1, H, -1, 0, 1'b0);
    join
    exp_frame(1, H, 0);
    send_frame(2, H, -1, 0, 1'b0);
    exp_frame(2, H, 0);
    drain_and_compare("t1_beats");
    check("t1_frame_cnt", frame_cnt, 2);
    check("t1_ovf", ovf_seen, 0);
    check("t1_fmt", fmt_seen, 0);

    // Pixels without a preceding vs falling edge are discarded.
    for (int xx = 0; xx < W; xx++) drive(1'b1, 1'b0, 1'b1, pix(99, 0, xx));
    idle(2);
    send_frame(3, H, -1, 0, 1'b0);
    exp_frame(3, H, 0);
    drain_and_compare("t2_beats");
    check("t2_frame_cnt", frame_cnt, 3);

    // Short line, then short frame, each followed by a good frame.
    send_frame(4, H, 1, 5, 1'b0);
    exp_frame(4, 1, 5);
    send_frame(5, H, -1, 0, 1'b0);
    exp_frame(5, H, 0);
    send_frame(6, 2, -1, 0, 1'b0);
    exp_frame(6, 2, 0);
    send_frame(7, H, -1, 0, 1'b0);
    exp_frame(7, H, 0);
    drain_and_compare("t3_beats");
    check("t3_fmt", fmt_seen, 2);
    check("t3_frame_cnt", frame_cnt, 5);

    // Overflow under full backpressure: 16 beats kept, 17th pixel dropped.
    m_axis_tready = 1'b0;
    send_frame(8, H, -1, 0, 1'b0);
    idle(2);
    check("t4_stall_valid", m_axis_tvalid, 1);
    check("t4_stall_head", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, {2'b10, pix(8, 0, 0)});
    check("t4_ovf", ovf_seen, 1);
    check("t4_frame_cnt_hold", frame_cnt, 5);
    m_axis_tready = 1'b1;
    exp_frame(8, 2, 0);
    drain_and_compare("t4_drain");
    send_frame(9, H, -1, 0, 1'b0);
    exp_frame(9, H, 0);
    drain_and_compare("t4_next");
    check("t4_frame_cnt", frame_cnt, 6);
    check("t4_ovf_once", ovf_seen, 1);

    // Clock enable toggling with de held high.
    send_frame(10, H, -1, 0, 1'b1);
    exp_frame(10, H, 0);
    drain_and_compare("t5_beats");
    check("t5_frame_cnt", frame_cnt, 7);

    // Asynchronous reset mid-line with a stalled valid beat.
    m_axis_tready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 24'h0);
    drive(1'b1, 1'b1, 1'b0, 24'h0);
    idle(2);
    for (int xx = 0; xx < 6; xx++) drive(1'b1, 1'b0, 1'b1, pix(11, 0, xx));
    check("t6_pre_valid", m_axis_tvalid, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_tvalid", m_axis_tvalid, 0);
    check("t6_rst_frame_cnt", frame_cnt, 0);
    check("t6_rst_head", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, 0);
    vid_de = 1'b0;
    repeat (2) @(posedge pclk);
    #2 rst = 1'b0;
    act_q.delete();
    exp_q.delete();
    m_axis_tready = 1'b1;
    for (int xx = 0; xx < W; xx++) drive(1'b1, 1'b0, 1'b1, pix(12, 0, xx));
    idle(10);
    check("t6_no_output", act_q.size(), 0);
    send_frame(13, H, -1, 0, 1'b0);
    exp_frame(13, H, 0);
    drain_and_compare("t6_beats");
    check("t6_frame_cnt", frame_cnt, 1);
    check("t6_fmt", fmt_seen, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
